// File: rtl/rpn_calc_pkg.sv
// Shared types and constants for the RPN calculator: status codes, FSM states,
// ASCII command bytes and the hex-digit decoder.
package rpn_calc_pkg;

  typedef enum logic [2:0] {
    ERR_OK        = 3'd0,
    ERR_BADCHAR   = 3'd1,
    ERR_UNDERFLOW = 3'd2,
    ERR_FULL      = 3'd3,
    ERR_BUSY      = 3'd4
  } err_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_PUSH,
    S_EXEC,
    S_MUL,
    S_DONE
  } state_t;

  localparam logic [7:0] SPACE  = 8'h20;
  localparam logic [7:0] CR     = 8'h0D;
  localparam logic [7:0] ESC    = 8'h1B;
  localparam logic [7:0] PLUS   = 8'h2B;
  localparam logic [7:0] MINUS  = 8'h2D;
  localparam logic [7:0] STAR   = 8'h2A;
  localparam logic [7:0] EQUALS = 8'h3D;

  // Returns {is_hex, nibble}; nibble is 0 for non-hex bytes.
  function automatic logic [4:0] ascii_to_nibble(input logic [7:0] c);
    if (c >= "0" && c <= "9")      return {1'b1, c[3:0]};
    else if (c >= "A" && c <= "F") return {1'b1, c[3:0] + 4'd9};
    else if (c >= "a" && c <= "f") return {1'b1, c[3:0] + 4'd9};
    else                           return 5'd0;
  endfunction

endpackage

// File: rtl/seq_multiplier.sv
// Shift-add multiplier, one multiplier bit per cycle; the first bit is folded
// into the start cycle so done pulses exactly WIDTH cycles after start.
module seq_multiplier #(
  parameter int WIDTH = 16
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);
  localparam int CW = $clog2(WIDTH + 1);

  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [CW-1:0]      cnt;
  logic               run;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      product <= '0;
      mcand   <= '0;
      mplier  <= '0;
      cnt     <= '0;
      run     <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        product <= b[0] ? {{WIDTH{1'b0}}, a} : '0;
        mcand   <= {{(WIDTH-1){1'b0}}, a, 1'b0};
        mplier  <= b >> 1;
        cnt     <= CW'(WIDTH - 1);
        run     <= 1'b1;
      end else if (run) begin
        if (mplier[0]) product <= product + mcand;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt - CW'(1);
        if (cnt == CW'(1)) begin
          run  <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/rpn_uart_calc_core.sv
// RPN calculator engine fed by UART bytes: hex entry, DEPTH-deep stack, + - *.
// Bytes are taken only in IDLE; a byte strobed while busy is dropped and flagged.
module rpn_uart_calc_core
  import rpn_calc_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       byte_ready,
  input  logic [7:0]                 byte_data,
  output logic [WIDTH-1:0]           result,
  output logic                       result_valid,
  output logic [$clog2(DEPTH+1)-1:0] depth,
  output logic                       busy,
  output logic                       overflow,
  output logic [2:0]                 error
);
  localparam int DW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(DEPTH);
  localparam logic [DW-1:0] FULL_SP = DW'(DEPTH);
  localparam logic [DW-1:0] ONE     = DW'(1);
  localparam logic [DW-1:0] TWO     = DW'(2);

  state_t state, state_nxt;

  logic [WIDTH-1:0]   stack [DEPTH];
  logic [DW-1:0]      sp;
  logic [WIDTH-1:0]   entry;
  logic               pending;
  logic [7:0]         cmd;
  logic               with_push;
  err_t               cmd_err;
  logic               busy_hit;

  logic [4:0]         hex;
  logic               is_sep, is_op, underflow, borrow;
  logic [IW-1:0]      top_idx, nxt_idx, push_idx, res_idx;
  logic [WIDTH-1:0]   op_a, op_b, diff;
  logic [WIDTH:0]     sum;
  logic               mul_start, mul_done;
  logic [2*WIDTH-1:0] mul_product;

  assign hex    = ascii_to_nibble(cmd);
  assign is_sep = (cmd == SPACE) || (cmd == CR);
  assign is_op  = (cmd == PLUS) || (cmd == MINUS) || (cmd == STAR);

  assign top_idx  = (sp == '0) ? '0 : IW'(sp - ONE);
  assign nxt_idx  = (sp < TWO) ? '0 : IW'(sp - TWO);
  assign push_idx = IW'(sp);

  // The implicit push is never written early: the pending entry acts as B in
  // place, so depth/result move only together with result_valid.
  assign op_a      = with_push ? stack[top_idx] : stack[nxt_idx];
  assign op_b      = with_push ? entry : stack[top_idx];
  assign res_idx   = with_push ? top_idx : nxt_idx;
  assign underflow = with_push ? (sp == '0) : (sp < TWO);

  assign sum    = {1'b0, op_a} + {1'b0, op_b};
  assign diff   = op_a - op_b;
  assign borrow = op_a < op_b;

  assign mul_start = (state == S_EXEC) && (cmd == STAR) && !underflow;

  seq_multiplier #(.WIDTH(WIDTH)) u_mul (
    .clock   (clock),
    .reset_n (reset_n),
    .start   (mul_start),
    .a       (op_a),
    .b       (op_b),
    .done    (mul_done),
    .product (mul_product)
  );

  assign result = (sp == '0) ? '0 : stack[top_idx];
  assign depth  = sp;
  assign busy   = (state != S_IDLE);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (byte_ready) state_nxt = S_DECODE;
      S_DECODE: begin
        if (is_op && !(pending && sp == FULL_SP))
          state_nxt = pending ? S_PUSH : S_EXEC;
        else
          state_nxt = S_DONE;
      end
      S_PUSH:   state_nxt = S_EXEC;
      S_EXEC:   state_nxt = mul_start ? S_MUL : S_DONE;
      S_MUL:    if (mul_done) state_nxt = S_DONE;
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) stack[i] <= '0;
      sp           <= '0;
      entry        <= '0;
      pending      <= 1'b0;
      cmd          <= '0;
      with_push    <= 1'b0;
      cmd_err      <= ERR_OK;
      busy_hit     <= 1'b0;
      result_valid <= 1'b0;
      overflow     <= 1'b0;
      error        <= ERR_OK;
    end else begin
      result_valid <= 1'b0;
      case (state)
        S_IDLE: if (byte_ready) cmd <= byte_data;
        S_DECODE: begin
          cmd_err <= ERR_OK;
          if (hex[4]) begin
            if (entry[WIDTH-1 -: 4] != 4'd0) overflow <= 1'b1;
            entry   <= {entry[WIDTH-5:0], hex[3:0]};
            pending <= 1'b1;
          end else if (is_sep) begin
            if (pending) begin
              if (sp == FULL_SP) cmd_err <= ERR_FULL;
              else begin
                stack[push_idx] <= entry;
                sp              <= sp + ONE;
                result_valid    <= 1'b1;
              end
            end
            entry   <= '0;
            pending <= 1'b0;
          end else if (is_op) begin
            if (pending && sp == FULL_SP) begin
              cmd_err <= ERR_FULL;
              entry   <= '0;
              pending <= 1'b0;
            end else begin
              with_push <= pending;
            end
          end else if (cmd == EQUALS) begin
            result_valid <= 1'b1;
          end else if (cmd == ESC) begin
            for (int i = 0; i < DEPTH; i++) stack[i] <= '0;
            sp           <= '0;
            entry        <= '0;
            pending      <= 1'b0;
            overflow     <= 1'b0;
            error        <= ERR_OK;
            result_valid <= 1'b1;
          end else begin
            cmd_err <= ERR_BADCHAR;
          end
        end
        S_EXEC: begin
          if (underflow) begin
            cmd_err      <= ERR_UNDERFLOW;
            result_valid <= 1'b1;
            if (with_push) begin
              stack[push_idx] <= entry;
              sp              <= sp + ONE;
            end
          end else if (cmd != STAR) begin
            if (cmd == PLUS) begin
              stack[res_idx] <= sum[WIDTH-1:0];
              if (sum[WIDTH]) overflow <= 1'b1;
            end else begin
              stack[res_idx] <= diff;
              if (borrow) overflow <= 1'b1;
            end
            result_valid <= 1'b1;
            if (!with_push) sp <= sp - ONE;
          end
        end
        S_MUL: begin
          if (mul_done) begin
            stack[res_idx] <= mul_product[WIDTH-1:0];
            if (mul_product[2*WIDTH-1:WIDTH] != '0) overflow <= 1'b1;
            result_valid <= 1'b1;
            if (!with_push) sp <= sp - ONE;
          end
        end
        S_DONE: begin
          if (!busy_hit) error <= cmd_err;
          busy_hit <= 1'b0;
          if (is_op) begin
            entry   <= '0;
            pending <= 1'b0;
          end
        end
        default: ;
      endcase
      // Placed last so a dropped byte's BUSY code wins over a same-cycle DONE.
      if (byte_ready && state != S_IDLE) begin
        error    <= ERR_BUSY;
        busy_hit <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rpn_uart_calc_core.sv
// Bench for rpn_uart_calc_core (WIDTH=16, DEPTH=4): byte vectors with expected
// status, and a scoreboard checking every result_valid value and cycle.
module tb_rpn_uart_calc_core;
  import rpn_calc_pkg::*;

  localparam int W = 16;
  localparam int D = 4;

  logic         clock = 1'b0;
  logic         reset_n = 1'b0;
  logic         byte_ready = 1'b0;
  logic [7:0]   byte_data = 8'h00;
  logic [W-1:0] result;
  logic         result_valid;
  logic [2:0]   depth;
  logic         busy;
  logic         overflow;
  logic [2:0]   error;

  rpn_uart_calc_core #(.WIDTH(W), .DEPTH(D)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .byte_ready   (byte_ready),
    .byte_data    (byte_data),
    .result       (result),
    .result_valid (result_valid),
    .depth        (depth),
    .busy         (busy),
    .overflow     (overflow),
    .error        (error)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [W-1:0] val;
    int           cyc;
  } exp_t;
  exp_t sbq[$];

  typedef struct {
    logic [7:0]   c;
    logic         v;
    logic [W-1:0] res;
    int           lat;
    int           dep;
    int           err;
    logic         ovf;
  } vec_t;
  vec_t vecs[$];

  task automatic check(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got 0x%0h, required 0x%0h", name, idx, act, exp);
    end
  endtask

  task automatic add(input logic [7:0] c, input logic v, input logic [W-1:0] res,
                     input int lat, input int dep, input int err, input logic ovf);
    vec_t t;
    t.c = c; t.v = v; t.res = res; t.lat = lat;
    t.dep = dep; t.err = err; t.ovf = ovf;
    vecs.push_back(t);
  endtask

  // Called on a falling edge; the byte is sampled at the next rising edge.
  task automatic send(input logic [7:0] c, input logic v,
                      input logic [W-1:0] res, input int lat);
    exp_t e;
    byte_data  = c;
    byte_ready = 1'b1;
    if (v) begin
      e.val = res;
      e.cyc = cyc + lat;
      sbq.push_back(e);
    end
    @(negedge clock);
    byte_ready = 1'b0;
  endtask

  task automatic wait_idle(input int idx);
    int n = 0;
    while (busy && n < 200) begin
      @(negedge clock);
      n++;
    end
    check("idle_timeout", idx, busy, 0);
  endtask

  always @(negedge clock) begin
    if (reset_n && result_valid) begin
      if (sbq.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_valid[%0d]: got result_valid=1 result=0x%0h, required no pulse",
                 cyc, result);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        check("result_value", e.cyc, result, e.val);
        check("result_cycle", e.cyc, cyc, e.cyc);
      end
    end
  end

  initial begin
    int bcnt;

    // "12 34+" then "="
    add("1", 0, 16'h0000, 0, 0, 0, 0);
    add("2", 0, 16'h0000, 0, 0, 0, 0);
    add(" ", 1, 16'h0012, 2, 1, 0, 0);
    add("3", 0, 16'h0012, 0, 1, 0, 0);
    add("4", 0, 16'h0012, 0, 1, 0, 0);
    add("+", 1, 16'h0046, 4, 1, 0, 0);
    add("=", 1, 16'h0046, 2, 1, 0, 0);
    add(ESC, 1, 16'h0000, 2, 0, 0, 0);
    // "FFFF 1+" carry, then ESC clears overflow
    for (int k = 0; k < 4; k++) add("F", 0, 16'h0000, 0, 0, 0, 0);
    add(" ", 1, 16'hFFFF, 2, 1, 0, 0);
    add("1", 0, 16'hFFFF, 0, 1, 0, 0);
    add("+", 1, 16'h0000, 4, 1, 0, 1);
    add(ESC, 1, 16'h0000, 2, 0, 0, 0);
    // "3-" underflow after implicit push
    add("3", 0, 16'h0000, 0, 0, 0, 0);
    add("-", 1, 16'h0003, 4, 1, 2, 0);
    add(ESC, 1, 16'h0000, 2, 0, 0, 0);
    // subtraction without/with implicit push, and borrow
    add("5", 0, 16'h0000, 0, 0, 0, 0);
    add(" ", 1, 16'h0005, 2, 1, 0, 0);
    add("3", 0, 16'h0005, 0, 1, 0, 0);
    add(" ", 1, 16'h0003, 2, 2, 0, 0);
    add("-", 1, 16'h0002, 3, 1, 0, 0);
    add("1", 0, 16'h0002, 0, 1, 0, 0);
    add(" ", 1, 16'h0001, 2, 2, 0, 0);
    add("-", 1, 16'h0001, 3, 1, 0, 0);
    add("3", 0, 16'h0001, 0, 1, 0, 0);
    add("-", 1, 16'hFFFE, 4, 1, 0, 1);
    add(ESC, 1, 16'h0000, 2, 0, 0, 0);
    // fill the stack, FULL on fifth push, BADCHAR, then operator at full depth
    add("1", 0, 16'h0000, 0, 0, 0, 0);
    add(" ", 1, 16'h0001, 2, 1, 0, 0);
    add("2", 0, 16'h0001, 0, 1, 0, 0);
    add(8'h0D, 1, 16'h0002, 2, 2, 0, 0);
    add("3", 0, 16'h0002, 0, 2, 0, 0);
    add(" ", 1, 16'h0003, 2, 3, 0, 0);
    add("4", 0, 16'h0003, 0, 3, 0, 0);
    add(" ", 1, 16'h0004, 2, 4, 0, 0);
    add("5", 0, 16'h0004, 0, 4, 0, 0);
    add(" ", 0, 16'h0004, 0, 4, 3, 0);
    add("g", 0, 16'h0004, 0, 4, 1, 0);
    add("+", 1, 16'h0007, 3, 3, 0, 0);
    add("9", 0, 16'h0007, 0, 3, 0, 0);
    add(" ", 1, 16'h0009, 2, 4, 0, 0);
    add("8", 0, 16'h0009, 0, 4, 0, 0);
    add("*", 0, 16'h0009, 0, 4, 3, 0);
    add(ESC, 1, 16'h0000, 2, 0, 0, 0);
    // operands for the multiply sequence
    add("1", 0, 16'h0000, 0, 0, 0, 0);
    add("2", 0, 16'h0000, 0, 0, 0, 0);
    add("3", 0, 16'h0000, 0, 0, 0, 0);
    add("4", 0, 16'h0000, 0, 0, 0, 0);
    add(" ", 1, 16'h1234, 2, 1, 0, 0);
    add("5", 0, 16'h1234, 0, 1, 0, 0);

    repeat (3) @(negedge clock);
    check("rst_result", 0, result, 0);
    check("rst_valid", 0, result_valid, 0);
    check("rst_depth", 0, depth, 0);
    check("rst_busy", 0, busy, 0);
    check("rst_overflow", 0, overflow, 0);
    check("rst_error", 0, error, 0);
    reset_n = 1'b1;
    @(negedge clock);

    foreach (vecs[i]) begin
      wait_idle(i);
      send(vecs[i].c, vecs[i].v, vecs[i].res, vecs[i].lat);
      wait_idle(i);
      check("result", i, result, vecs[i].res);
      check("depth", i, depth, vecs[i].dep);
      check("error", i, error, vecs[i].err);
      check("overflow", i, overflow, vecs[i].ovf);
    end

    // '*' with implicit push; a '7' strobed mid-multiply must be dropped
    send("*", 1, 16'h5B04, W + 4);
    bcnt = 1;
    for (int k = 0; k < 100 && busy; k++) begin
      if (k == 5) begin
        byte_data  = "7";
        byte_ready = 1'b1;
      end else begin
        byte_ready = 1'b0;
      end
      @(negedge clock);
      if (busy) bcnt++;
    end
    byte_ready = 1'b0;
    check("mul_busy_cycles", 0, bcnt, W + 4);
    check("mul_error_busy", 0, error, 4);
    check("mul_depth", 0, depth, 1);
    check("mul_result", 0, result, 16'h5B04);
    check("mul_overflow", 0, overflow, 0);
    send(" ", 0, 16'h0000, 0);
    wait_idle(1);
    check("dropped_entry_depth", 0, depth, 1);
    check("dropped_entry_error", 0, error, 0);

    // five digits truncate to 16 bits, then reset during a multiply
    send(ESC, 1, 16'h0000, 2);
    wait_idle(2);
    for (int k = 0; k < 5; k++) begin
      send("F", 0, 16'h0000, 0);
      wait_idle(3);
    end
    check("trunc_overflow", 0, overflow, 1);
    send(" ", 1, 16'hFFFF, 2);
    wait_idle(4);
    check("trunc_result", 0, result, 16'hFFFF);
    check("trunc_depth", 0, depth, 1);
    send("3", 0, 16'h0000, 0);
    wait_idle(5);
    send("*", 0, 16'h0000, 0);
    repeat (8) @(negedge clock);
    check("pre_rst_busy", 0, busy, 1);
    reset_n = 1'b0;
    #1;
    check("arst_result", 0, result, 0);
    check("arst_valid", 0, result_valid, 0);
    check("arst_depth", 0, depth, 0);
    check("arst_busy", 0, busy, 0);
    check("arst_overflow", 0, overflow, 0);
    check("arst_error", 0, error, 0);
    @(negedge clock);
    reset_n = 1'b1;
    repeat (40) @(negedge clock);
    check("post_rst_busy", 0, busy, 0);
    check("scoreboard_empty", 0, sbq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
